// File: rtl/dac_enc_pkg.sv
// Shared constants and types for the segmented DAC encoder (17 unary MSB cells + 7 binary LSBs).
package dac_enc_pkg;
  localparam int N_THERM = 17;
  localparam int N_BIN   = 7;
  localparam int CODE_W  = 12;
  localparam int UNIT_W  = 7;

  typedef logic [N_THERM-1:0] therm_t;
  typedef logic [N_BIN-1:0]   bin_t;
  typedef logic [4:0]         ptr_t;
  typedef logic [CODE_W-1:0]  code_t;

  localparam code_t CODE_MAX = 12'd2303;

  function automatic code_t sat_code(input code_t c);
    return (c > CODE_MAX) ? CODE_MAX : c;
  endfunction
endpackage

// File: rtl/dac_dwa_rotator.sv
// Combinational DWA cell selector: rotated n-of-17 mask and next pointer (mod 17).
module dac_dwa_rotator
  import dac_enc_pkg::*;
(
  input  logic [4:0] n_i,
  input  ptr_t       ptr_i,
  input  logic       dwa_en_i,
  output therm_t     mask_o,
  output ptr_t       ptr_nxt_o
);
  therm_t               base;
  ptr_t                 rot;
  logic [2*N_THERM-1:0] dbl;
  logic [5:0]           sum;

  always_comb begin
    base = '0;
    for (int i = 0; i < N_THERM; i++) base[i] = (5'(i) < n_i);
    rot = dwa_en_i ? ptr_i : '0;
    // Rotate within 17 bits by shifting a zero-extended copy and folding the overflow back.
    dbl    = {{N_THERM{1'b0}}, base} << rot;
    mask_o = dbl[N_THERM-1:0] | dbl[2*N_THERM-1:N_THERM];
    sum = {1'b0, ptr_i} + {1'b0, n_i};
    if (sum >= 6'd17) sum = sum - 6'd17;
    ptr_nxt_o = ptr_i;
    if (dwa_en_i && (n_i != 5'd0) && (n_i != 5'd17)) ptr_nxt_o = sum[4:0];
  end
endmodule

// File: rtl/dac_dwa_encoder.sv
// Two-stage DAC front-end encoder: saturating code capture, then DWA thermometer + binary LSBs.
// Optional PRBS7 test source enabled with DAC_DWA_ENC_PRBS_EN.
module dac_dwa_encoder
  import dac_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pdb,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  input  logic              dwa_en,
  input  logic              prbs_sel,
  output logic [N_THERM-1:0] dataintherm,
  output logic [N_THERM-1:0] datainthermb,
  output logic [N_BIN-1:0]   datainbin,
  output logic [N_BIN-1:0]   datainbinb,
  output logic              sat_flag,
  output logic [4:0]        ptr_out
);
  code_t  raw, c_q, c_d;
  logic   cap, sat1_q, sat1_d;
  therm_t therm_q, thermb_q, mask;
  bin_t   bin_q, binb_q;
  logic   sat_q;
  ptr_t   ptr_q, ptr_nxt;

`ifdef DAC_DWA_ENC_PRBS_EN
  logic [6:0] prbs_q, prbs_d;

  assign prbs_d = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      prbs_q <= 7'h7F;
    else if (pdb) prbs_q <= prbs_d;
  end

  assign raw = prbs_sel ? {prbs_q[4:0], prbs_q} : code_in;
  assign cap = code_valid | prbs_sel;
`else
  logic unused_prbs_sel;
  assign unused_prbs_sel = prbs_sel;
  assign raw = code_in;
  assign cap = code_valid;
`endif

  always_comb begin
    c_d    = c_q;
    sat1_d = sat1_q;
    if (cap) begin
      c_d    = sat_code(raw);
      sat1_d = (raw > CODE_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      sat1_q <= 1'b0;
    end else if (!pdb) begin
      c_q    <= '0;
      sat1_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      sat1_q <= sat1_d;
    end
  end

  dac_dwa_rotator u_rot (
    .n_i       (c_q[CODE_W-1:UNIT_W]),
    .ptr_i     (ptr_q),
    .dwa_en_i  (dwa_en),
    .mask_o    (mask),
    .ptr_nxt_o (ptr_nxt)
  );

  // True and complement are registered side by side so the latch sees them from one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !pdb) begin
      therm_q  <= '0;
      thermb_q <= '1;
      bin_q    <= '0;
      binb_q   <= '1;
      sat_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      therm_q  <= mask;
      thermb_q <= ~mask;
      bin_q    <= c_q[UNIT_W-1:0];
      binb_q   <= ~c_q[UNIT_W-1:0];
      sat_q    <= sat1_q;
      ptr_q    <= ptr_nxt;
    end
  end

  assign dataintherm  = therm_q;
  assign datainthermb = thermb_q;
  assign datainbin    = bin_q;
  assign datainbinb   = binb_q;
  assign sat_flag     = sat_q;
  assign ptr_out      = ptr_q;
endmodule

// File: tb/tb_dac_dwa_encoder.sv
// Directed-vector bench for dac_dwa_encoder with hand-computed expectations.
module tb_dac_dwa_encoder;
  logic        clk = 1'b0;
  logic        rst, pdb, code_valid, dwa_en, prbs_sel;
  logic [11:0] code_in;
  logic [16:0] dataintherm, datainthermb;
  logic [6:0]  datainbin, datainbinb;
  logic        sat_flag;
  logic [4:0]  ptr_out;
  int n_checks = 0;
  int n_fail   = 0;

  dac_dwa_encoder dut (
    .clk(clk), .rst(rst), .pdb(pdb), .code_in(code_in), .code_valid(code_valid),
    .dwa_en(dwa_en), .prbs_sel(prbs_sel), .dataintherm(dataintherm),
    .datainthermb(datainthermb), .datainbin(datainbin), .datainbinb(datainbinb),
    .sat_flag(sat_flag), .ptr_out(ptr_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [16:0] th, input logic [6:0] b,
                           input logic s, input logic [4:0] p);
    check({tag, ".therm"},  {15'd0, dataintherm}, {15'd0, th});
    check({tag, ".thermb"}, {15'd0, datainthermb}, {15'd0, ~th});
    check({tag, ".bin"},    {25'd0, datainbin}, {25'd0, b});
    check({tag, ".binb"},   {25'd0, datainbinb}, {25'd0, ~b});
    check({tag, ".sat"},    {31'd0, sat_flag}, {31'd0, s});
    check({tag, ".ptr"},    {27'd0, ptr_out}, {27'd0, p});
  endtask

  initial begin
    rst = 1'b1; pdb = 1'b0; code_valid = 1'b0; dwa_en = 1'b0; prbs_sel = 1'b0; code_in = '0;
    tick();
    check_out("reset", 17'h00000, 7'h00, 1'b0, 5'd0);
    rst = 1'b0;
    tick();

    // code 300: n=2, lsb=0x2C
    pdb = 1'b1; dwa_en = 1'b1; code_valid = 1'b1; code_in = 12'd300;
    tick();
    check_out("lat1", 17'h00000, 7'h00, 1'b0, 5'd0);
    code_in = 12'd0;
    tick();
    check_out("c300", 17'h00003, 7'h2C, 1'b0, 5'd2);

    // n=13 from ptr 2, then n=4 wraps from ptr 15
    code_in = 12'd1664;
    tick();
    code_in = 12'd512;
    tick();
    check_out("n13", 17'h07FFC, 7'h00, 1'b0, 5'd15);
    code_in = 12'd0;
    tick();
    check_out("wrap", 17'h18003, 7'h00, 1'b0, 5'd2);

    // saturation, then exact full scale
    code_in = 12'd4000;
    tick();
    code_in = 12'd2303;
    tick();
    check_out("sat4000", 17'h1FFFF, 7'h7F, 1'b1, 5'd2);
    code_in = 12'd0;
    tick();
    check_out("full2303", 17'h1FFFF, 7'h7F, 1'b0, 5'd2);

    // fixed selection, pointer held
    dwa_en = 1'b0; code_in = 12'd640;
    tick();
    tick();
    check_out("fix640a", 17'h0001F, 7'h00, 1'b0, 5'd2);
    code_in = 12'd0;
    tick();
    check_out("fix640b", 17'h0001F, 7'h00, 1'b0, 5'd2);

    // re-enable: rotation resumes from the retained pointer
    dwa_en = 1'b1; code_in = 12'd640;
    tick();
    code_in = 12'd0;
    tick();
    check_out("resume", 17'h0007C, 7'h00, 1'b0, 5'd7);

    // reach ptr 9 with outputs active, then async reset mid-cycle
    code_in = 12'd261;
    tick();
    tick();
    check_out("pre_rst", 17'h00180, 7'h05, 1'b0, 5'd9);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 17'h00000, 7'h00, 1'b0, 5'd0);
    rst = 1'b0;

    // hold code 384 (n=3): DWA keeps rotating on the re-emitted code
    code_in = 12'd384; code_valid = 1'b1;
    tick();
    code_valid = 1'b0; code_in = 12'd1000;
    tick();
    check_out("hold1", 17'h00007, 7'h00, 1'b0, 5'd3);
    tick();
    check_out("hold2", 17'h00038, 7'h00, 1'b0, 5'd6);
    tick();
    check_out("hold3", 17'h001C0, 7'h00, 1'b0, 5'd9);

    // power-down, then restart from pointer 0
    pdb = 1'b0;
    tick();
    check_out("pdb0", 17'h00000, 7'h00, 1'b0, 5'd0);
    pdb = 1'b1;
    tick();
    check_out("pdb_s1clr", 17'h00000, 7'h00, 1'b0, 5'd0);
    code_valid = 1'b1; code_in = 12'd384;
    tick();
    code_in = 12'd0;
    tick();
    check_out("restart", 17'h00007, 7'h00, 1'b0, 5'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
